// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the writeback stage and its load aligner:
// write-back source select, load funct3 encodings, writeback FSM states,
// and a helper that classifies illegal / misaligned loads.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LINK = 2'b01,
        WB_LOAD = 2'b10,
        WB_NONE = 2'b11
    } wb_select_e;

    typedef enum logic [2:0] {
        LF_LB  = 3'b000,
        LF_LH  = 3'b001,
        LF_LW  = 3'b010,
        LF_LBU = 3'b100,
        LF_LHU = 3'b101
    } load_funct_e;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

    // A load is illegal when its funct3 is unassigned or its byte offset
    // breaks natural alignment for the access size.
    function automatic logic load_is_illegal(input logic [2:0] funct,
                                             input logic [1:0] offset);
        logic illegal;
        illegal = 1'b0;
        case (funct)
            LF_LB, LF_LBU: illegal = 1'b0;
            LF_LH, LF_LHU: illegal = offset[0];
            LF_LW:         illegal = (offset != 2'b00);
            default:       illegal = 1'b1;
        endcase
        return illegal;
    endfunction

endpackage

// File: rtl/writeback_stage_load_aligner.sv
// load_aligner: picks the addressed byte / halfword out of an aligned
// memory word and sign- or zero-extends it according to the load funct3.
// Purely combinational.
module load_aligner
    import cpu_pkg::*;
(
    input  logic [2:0]      funct,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]             byte_u;
    logic [15:0]            half_u;
    logic signed [XLEN-1:0] byte_sx;
    logic signed [XLEN-1:0] half_sx;

    // Lane selection and extension of the loaded word
    always_comb begin
        byte_u = rdata[7:0];
        case (offset)
            2'd0: byte_u = rdata[7:0];
            2'd1: byte_u = rdata[15:8];
            2'd2: byte_u = rdata[23:16];
            2'd3: byte_u = rdata[31:24];
            default: byte_u = rdata[7:0];
        endcase
        half_u  = offset[1] ? rdata[31:16] : rdata[15:0];
        byte_sx = XLEN'($signed(byte_u));
        half_sx = XLEN'($signed(half_u));

        data = rdata;
        case (funct)
            LF_LB:   data = byte_sx;
            LF_LBU:  data = {{(XLEN-8){1'b0}}, byte_u};
            LF_LH:   data = half_sx;
            LF_LHU:  data = {{(XLEN-16){1'b0}}, half_u};
            LF_LW:   data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Selects ALU result, link address
// or aligned load data and drives the register-file write port. Loads wait
// in WAIT_LOAD (stalling upstream) until memory returns data.
// Optional feature macro: WRITEBACK_BYPASS_EN adds fwd_valid/fwd_rd/fwd_data
// so operand fetch can bypass a same-cycle register-file write.
module writeback_stage #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_enable,
    input  logic                wb_valid,
    input  logic [1:0]          wb_select,
    input  logic [4:0]          wb_rd,
    input  logic [2:0]          load_funct,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [PC_WIDTH-1:0] pc_s2,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                stall,
    output logic                reg_we,
    output logic [4:0]          reg_rd,
    output logic [XLEN-1:0]     reg_data,
`ifdef WRITEBACK_BYPASS_EN
    output logic                fwd_valid,
    output logic [4:0]          fwd_rd,
    output logic [XLEN-1:0]     fwd_data,
`endif
    output logic                load_fault
);

    import cpu_pkg::*;

    wb_state_e         state, state_nxt;
    wb_select_e        sel;

    // Load context captured at accept time
    logic [4:0]        rd_q;
    logic [2:0]        funct_q;
    logic [1:0]        offset_q;

    logic              capture;
    logic              we_nxt;
    logic              fault_nxt;
    logic [4:0]        rd_nxt;
    logic [XLEN-1:0]   data_nxt;
    logic [XLEN-1:0]   load_data;
    logic [PC_WIDTH-1:0] link_pc;
    logic              load_illegal;

    assign sel          = wb_select_e'(wb_select);
    assign link_pc      = pc_s2 + PC_WIDTH'(1);
    assign load_illegal = load_is_illegal(load_funct, alu_result[1:0]);

    load_aligner u_load_aligner (
        .funct  (funct_q),
        .offset (offset_q),
        .rdata  (mem_rdata),
        .data   (load_data)
    );

    // FSM state register; reset wins over clk_enable so a pending load is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (clk_enable) begin
            state <= state_nxt;
        end
    end

    // Next-state: enter WAIT_LOAD on a legal load, leave it when data arrives
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wb_valid && sel == WB_LOAD && !load_illegal) begin
                    state_nxt = WAIT_LOAD;
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: next values for the write port, fault pulse and load capture
    always_comb begin
        we_nxt    = 1'b0;
        fault_nxt = 1'b0;
        rd_nxt    = reg_rd;
        data_nxt  = reg_data;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (wb_valid) begin
                    case (sel)
                        WB_ALU: begin
                            rd_nxt   = wb_rd;
                            data_nxt = alu_result;
                            we_nxt   = (wb_rd != 5'd0);
                        end
                        WB_LINK: begin
                            rd_nxt   = wb_rd;
                            data_nxt = {link_pc, 2'b00};
                            we_nxt   = (wb_rd != 5'd0);
                        end
                        WB_LOAD: begin
                            if (load_illegal) begin
                                fault_nxt = 1'b1;
                            end else begin
                                capture = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    rd_nxt   = rd_q;
                    data_nxt = load_data;
                    we_nxt   = (rd_q != 5'd0);
                end
            end
            default: ;
        endcase
    end

    // Registered write port, fault pulse and captured load context
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_we     <= 1'b0;
            reg_rd     <= 5'd0;
            reg_data   <= '0;
            load_fault <= 1'b0;
            rd_q       <= 5'd0;
            funct_q    <= 3'd0;
            offset_q   <= 2'd0;
        end else if (clk_enable) begin
            reg_we     <= we_nxt;
            reg_rd     <= rd_nxt;
            reg_data   <= data_nxt;
            load_fault <= fault_nxt;
            if (capture) begin
                rd_q     <= wb_rd;
                funct_q  <= load_funct;
                offset_q <= alu_result[1:0];
            end
        end
    end

    assign stall = (state == WAIT_LOAD);

`ifdef WRITEBACK_BYPASS_EN
    // Same-cycle forwarding of the write the register file is about to take
    assign fwd_valid = reg_we & clk_enable;
    assign fwd_rd    = reg_rd;
    assign fwd_data  = reg_data;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed scenarios followed by random
// stimulus, all checked against a behavioural model of the stage.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        wb_valid;
    logic [1:0]  wb_select;
    logic [4:0]  wb_rd;
    logic [2:0]  load_funct;
    logic [31:0] alu_result;
    logic [29:0] pc_s2;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        reg_we;
    logic [4:0]  reg_rd;
    logic [31:0] reg_data;
    logic        load_fault;
`ifdef WRITEBACK_BYPASS_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int total = 0;
    int bad   = 0;

    // Model state
    bit          m_pend;
    bit [4:0]    m_prd;
    bit [2:0]    m_pf;
    bit [1:0]    m_poff;
    bit          m_we;
    bit [4:0]    m_rd;
    bit [31:0]   m_data;
    bit          m_fault;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .wb_valid   (wb_valid),
        .wb_select  (wb_select),
        .wb_rd      (wb_rd),
        .load_funct (load_funct),
        .alu_result (alu_result),
        .pc_s2      (pc_s2),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .reg_we     (reg_we),
        .reg_rd     (reg_rd),
        .reg_data   (reg_data),
`ifdef WRITEBACK_BYPASS_EN
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
`endif
        .load_fault (load_fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal_load(input bit [2:0] f, input bit [1:0] off);
        if (f == 3'd0 || f == 3'd4) return 1'b1;
        if (f == 3'd1 || f == 3'd5) return (off % 2) == 0;
        if (f == 3'd2) return off == 0;
        return 1'b0;
    endfunction

    // Expected load value from plain shift/mask arithmetic
    function automatic bit [31:0] load_value(input bit [2:0] f, input bit [1:0] off, input bit [31:0] w);
        bit [31:0] sh;
        bit [31:0] v;
        sh = w >> (8 * off);
        case (f)
            3'd0: begin v = sh & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
            3'd4: v = sh & 32'hFF;
            3'd1: begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            3'd5: v = sh & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // Apply one cycle of inputs, check combinational outputs, clock, update model, check registers
    task automatic step(input bit r, input bit en, input bit v, input bit [1:0] sel,
                        input bit [4:0] rd, input bit [2:0] f, input bit [31:0] alu,
                        input bit [29:0] pc, input bit rv, input bit [31:0] rdata);
        reset = r; clk_enable = en; wb_valid = v; wb_select = sel; wb_rd = rd;
        load_funct = f; alu_result = alu; pc_s2 = pc; mem_rvalid = rv; mem_rdata = rdata;
        #1;
        check_eq("stall", 32'(stall), 32'(m_pend));
`ifdef WRITEBACK_BYPASS_EN
        check_eq("fwd_valid", 32'(fwd_valid), 32'(m_we && en));
        check_eq("fwd_rd", 32'(fwd_rd), 32'(m_rd));
        check_eq("fwd_data", fwd_data, m_data);
`endif
        @(posedge clk);
        if (r) begin
            m_pend = 0; m_prd = 0; m_pf = 0; m_poff = 0;
            m_we = 0; m_rd = 0; m_data = 0; m_fault = 0;
        end else if (en) begin
            m_we = 0; m_fault = 0;
            if (!m_pend) begin
                if (v) begin
                    if (sel == 2'd0) begin
                        m_rd = rd; m_data = alu; m_we = (rd != 0);
                    end else if (sel == 2'd1) begin
                        m_rd = rd; m_data = (32'(pc) + 32'd1) * 4; m_we = (rd != 0);
                    end else if (sel == 2'd2) begin
                        if (legal_load(f, alu[1:0])) begin
                            m_pend = 1; m_prd = rd; m_pf = f; m_poff = alu[1:0];
                        end else begin
                            m_fault = 1;
                        end
                    end
                end
            end else if (rv) begin
                m_rd = m_prd; m_data = load_value(m_pf, m_poff, rdata);
                m_we = (m_prd != 0); m_pend = 0;
            end
        end
        @(negedge clk);
        check_eq("reg_we", 32'(reg_we), 32'(m_we));
        check_eq("reg_rd", 32'(reg_rd), 32'(m_rd));
        check_eq("reg_data", reg_data, m_data);
        check_eq("load_fault", 32'(load_fault), 32'(m_fault));
    endtask

    initial begin
        reset = 1; clk_enable = 1; wb_valid = 0; wb_select = 0; wb_rd = 0;
        load_funct = 0; alu_result = 0; pc_s2 = 0; mem_rvalid = 0; mem_rdata = 0;
        m_pend = 0; m_prd = 0; m_pf = 0; m_poff = 0;
        m_we = 0; m_rd = 0; m_data = 0; m_fault = 0;
        @(negedge clk);

        // Reset state
        step(1, 1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0, 0, 32'h0);
        step(1, 1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0, 0, 32'h0);
        check_eq("rst_we", 32'(reg_we), 32'd0);
        check_eq("rst_data", reg_data, 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);

        // ALU write
        step(0, 1, 1, 2'd0, 5'd5, 3'd0, 32'hDEADBEEF, 30'h0, 0, 32'h0);
        check_eq("alu_we", 32'(reg_we), 32'd1);
        check_eq("alu_rd", 32'(reg_rd), 32'd5);
        check_eq("alu_data", reg_data, 32'hDEADBEEF);

        // LINK wrap and rd=0
        step(0, 1, 1, 2'd1, 5'd1, 3'd0, 32'h0, 30'h3FFFFFFF, 0, 32'h0);
        check_eq("link_wrap", reg_data, 32'h0);
        check_eq("link_we", 32'(reg_we), 32'd1);
        step(0, 1, 1, 2'd1, 5'd0, 3'd0, 32'h0, 30'h00000010, 0, 32'h0);
        check_eq("link_rd0_we", 32'(reg_we), 32'd0);
        check_eq("link_rd0_data", reg_data, 32'h44);

        // LB at offset 3, data three cycles later
        step(0, 1, 1, 2'd2, 5'd7, 3'd0, 32'h1003, 30'h0, 0, 32'h0);
        check_eq("lb_stall1", 32'(stall), 32'd1);
        step(0, 1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0, 0, 32'h0);
        check_eq("lb_stall2", 32'(stall), 32'd1);
        step(0, 1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0, 0, 32'h0);
        check_eq("lb_stall3", 32'(stall), 32'd1);
        step(0, 1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0, 1, 32'h80123456);
        check_eq("lb_data", reg_data, 32'hFFFFFF80);
        check_eq("lb_we", 32'(reg_we), 32'd1);
        check_eq("lb_done", 32'(stall), 32'd0);
        step(0, 1, 1, 2'd2, 5'd7, 3'd4, 32'h1003, 30'h0, 0, 32'h0);
        step(0, 1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0, 1, 32'h80123456);
        check_eq("lbu_data", reg_data, 32'h00000080);

        // Illegal loads
        step(0, 1, 1, 2'd2, 5'd3, 3'd1, 32'h2001, 30'h0, 0, 32'h0);
        check_eq("lh_mis_fault", 32'(load_fault), 32'd1);
        check_eq("lh_mis_we", 32'(reg_we), 32'd0);
        check_eq("lh_mis_stall", 32'(stall), 32'd0);
        step(0, 1, 1, 2'd2, 5'd3, 3'd2, 32'h2002, 30'h0, 0, 32'h0);
        check_eq("lw_mis_fault", 32'(load_fault), 32'd1);
        step(0, 1, 1, 2'd2, 5'd3, 3'd7, 32'h2000, 30'h0, 0, 32'h0);
        check_eq("f7_fault", 32'(load_fault), 32'd1);
        step(0, 1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0, 0, 32'h0);
        check_eq("fault_pulse", 32'(load_fault), 32'd0);

        // Reset while waiting for load data
        step(0, 1, 1, 2'd2, 5'd9, 3'd2, 32'h3000, 30'h0, 0, 32'h0);
        step(1, 1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0, 0, 32'h0);
        step(0, 1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0, 1, 32'h12345678);
        check_eq("rst_wait_we", 32'(reg_we), 32'd0);
        check_eq("rst_wait_stall", 32'(stall), 32'd0);

        // clk_enable low while data is waiting
        step(0, 1, 1, 2'd2, 5'd12, 3'd2, 32'h4000, 30'h0, 0, 32'h0);
        step(0, 0, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0, 1, 32'hCAFEF00D);
        check_eq("en0_we", 32'(reg_we), 32'd0);
        check_eq("en0_stall", 32'(stall), 32'd1);
        step(0, 0, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0, 1, 32'hCAFEF00D);
        step(0, 1, 0, 2'd0, 5'd0, 3'd0, 32'h0, 30'h0, 1, 32'hCAFEF00D);
        check_eq("en1_we", 32'(reg_we), 32'd1);
        check_eq("en1_data", reg_data, 32'hCAFEF00D);
        check_eq("en1_rd", 32'(reg_rd), 32'd12);
        // Hold the write for a cycle with enable low
        step(0, 0, 1, 2'd0, 5'd4, 3'd0, 32'h11111111, 30'h0, 0, 32'h0);
        check_eq("hold_data", reg_data, 32'hCAFEF00D);

        // Random stimulus
        for (int i = 0; i < 600; i++) begin
            bit        r;
            bit        en;
            bit [4:0]  rd;
            r  = ($urandom_range(0, 99) < 2);
            en = r ? 1'b1 : ($urandom_range(0, 99) < 85);
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step(r, en, 1'($urandom), 2'($urandom), rd, 3'($urandom),
                 $urandom, 30'($urandom), ($urandom_range(0, 99) < 40), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
